// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches one block as back-to-back word reads and
// streams returned words into the data array, writing the tag on the last word.
module cache_fill_fsm #(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned AWIDTH          = 16,
    parameter int unsigned DWIDTH          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [AWIDTH-1:0]                  miss_address,
    input  logic                               memory_data_valid,
    input  logic [DWIDTH-1:0]                  memory_data,
    output logic                               fsm_busy,
    output logic                               memory_read_en,
    output logic [AWIDTH-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic [DWIDTH-1:0]                  cache_wr_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_wr_offset,
    output logic                               write_tag_array,
    output logic                               fill_done
);
    localparam int unsigned OFFW        = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNTW        = OFFW + 1;
    localparam int unsigned BYTE_SHIFT  = $clog2(DWIDTH / 8);
    localparam int unsigned BLOCK_BYTES = WORDS_PER_BLOCK * (DWIDTH / 8);
    localparam logic [AWIDTH-1:0] BASE_MASK = ~AWIDTH'(BLOCK_BYTES - 1);
    localparam logic [CNTW-1:0]   CNT_FULL  = CNTW'(WORDS_PER_BLOCK);
    localparam logic [CNTW-1:0]   CNT_LAST  = CNTW'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            r_state;
    logic [AWIDTH-1:0] r_base;
    logic [CNTW-1:0]   r_req_cnt;
    logic [CNTW-1:0]   r_resp_cnt;

    logic w_in_fill;
    logic w_req_active;
    logic w_resp_accept;
    logic w_last_word;

    assign w_in_fill     = (r_state == FILL);
    assign w_req_active  = w_in_fill && (r_req_cnt < CNT_FULL);
    // Responses beyond a full block are dropped so the counter never wraps.
    assign w_resp_accept = w_in_fill && memory_data_valid && (r_resp_cnt < CNT_FULL);
    assign w_last_word   = w_resp_accept && (r_resp_cnt == CNT_LAST);

    // State, latched block base and request/response counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_req_cnt  <= '0;
            r_resp_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_detected) begin
                        r_base     <= miss_address & BASE_MASK;
                        r_req_cnt  <= '0;
                        r_resp_cnt <= '0;
                        r_state    <= FILL;
                    end
                end
                FILL: begin
                    if (w_req_active) begin
                        r_req_cnt <= r_req_cnt + CNTW'(1);
                    end
                    if (w_resp_accept) begin
                        r_resp_cnt <= r_resp_cnt + CNTW'(1);
                    end
                    if (w_last_word) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stall asserts in the miss cycle itself, before the FSM has left IDLE.
    always_comb begin
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        cache_wr_data    = '0;
        cache_wr_offset  = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;

        if (!rst) begin
            fsm_busy = w_in_fill || miss_detected;
        end
        if (w_in_fill) begin
            memory_read_en = w_req_active;
            memory_address = w_req_active
                           ? r_base + (AWIDTH'(r_req_cnt) << BYTE_SHIFT)
                           : r_base;
        end
        if (w_resp_accept) begin
            write_data_array = 1'b1;
            cache_wr_data    = memory_data;
            cache_wr_offset  = r_resp_cnt[OFFW-1:0];
        end
        write_tag_array = w_last_word;
        fill_done       = w_last_word;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed vector bench for cache_fill_fsm: per-cycle stimulus/expectation
// records, plus aggregate checks on busy length, request count and done timing.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] cache_wr_data;
    logic [2:0]  cache_wr_offset;
    logic        write_tag_array;
    logic        fill_done;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .cache_wr_data     (cache_wr_data),
        .cache_wr_offset   (cache_wr_offset),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        miss;
        logic [15:0] maddr;
        logic        dv;
        logic [15:0] mdata;
        logic        full_chk;
        logic        e_busy;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_wr;
        logic [15:0] e_data;
        logic [2:0]  e_off;
        logic        e_tag;
        logic        e_done;
    } vec_t;

    vec_t vq[$];
    int   n_vec;
    int   n_err;
    int   busy_cnt;
    int   rd_cnt;
    int   tag_cnt;
    int   wr_cnt;
    int   zero_req;
    int   sec_idx;
    int   done_idx;

    function automatic vec_t idle_vec();
        vec_t v;
        v.rst = 1'b0; v.miss = 1'b0; v.maddr = 16'h0; v.dv = 1'b0; v.mdata = 16'h0;
        v.full_chk = 1'b0; v.e_busy = 1'b0; v.e_rd = 1'b0; v.e_addr = 16'h0;
        v.e_wr = 1'b0; v.e_data = 16'h0; v.e_off = 3'd0; v.e_tag = 1'b0; v.e_done = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] wdata(input logic [15:0] base, input int j);
        return base ^ 16'(j * 16'h1111) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at vector %0d: got 0x%0h, expected 0x%0h", nm, n_vec, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst               = v.rst;
        miss_detected     = v.miss;
        miss_address      = v.maddr;
        memory_data_valid = v.dv;
        memory_data       = v.mdata;
        #1;
        n_vec++;
        chk("fsm_busy",         int'(fsm_busy),         int'(v.e_busy));
        chk("memory_read_en",   int'(memory_read_en),   int'(v.e_rd));
        chk("write_data_array", int'(write_data_array), int'(v.e_wr));
        chk("write_tag_array",  int'(write_tag_array),  int'(v.e_tag));
        chk("fill_done",        int'(fill_done),        int'(v.e_done));
        if (v.full_chk || v.e_busy)
            chk("memory_address", int'(memory_address), int'(v.e_addr));
        if (v.full_chk || v.e_wr) begin
            chk("cache_wr_data",   int'(cache_wr_data),   int'(v.e_data));
            chk("cache_wr_offset", int'(cache_wr_offset), int'(v.e_off));
        end
        if (fsm_busy === 1'b1) busy_cnt++;
        if (memory_read_en === 1'b1) rd_cnt++;
        if (write_tag_array === 1'b1) tag_cnt++;
        if (write_data_array === 1'b1) wr_cnt++;
        if (memory_read_en === 1'b1 && memory_address == 16'h0000) zero_req++;
        if (fill_done === 1'b1) done_idx = sec_idx;
        sec_idx++;
    endtask

    task automatic run_section();
        busy_cnt = 0; rd_cnt = 0; tag_cnt = 0; wr_cnt = 0;
        zero_req = 0; sec_idx = 0; done_idx = -1;
        foreach (vq[i]) apply(vq[i]);
        vq.delete();
    endtask

    // Expected trace of one fill against a 4-cycle memory; response j arrives
    // in FILL cycle 4+j, pushed back by gap_len cycles from word gap_at onward.
    task automatic build_fill(input logic [15:0] maddr, input int gap_at, input int gap_len,
                              input int stop_at, input bit spurious, input bit idle_after);
        vec_t        v;
        logic [15:0] base;
        int          resp_cyc[8];
        int          last;
        int          nresp;
        base = maddr & 16'hFFF0;
        for (int j = 0; j < 8; j++)
            resp_cyc[j] = 4 + j + ((j >= gap_at) ? gap_len : 0);
        last = resp_cyc[stop_at - 1];
        v = idle_vec(); v.miss = 1'b1; v.maddr = maddr; v.e_busy = 1'b1;
        vq.push_back(v);
        nresp = 0;
        for (int k = 0; k <= last; k++) begin
            v = idle_vec();
            v.e_busy = 1'b1;
            if (spurious && (k % 3 == 1)) begin
                v.miss = 1'b1; v.maddr = 16'h7776;
            end
            v.e_rd   = (k < 8);
            v.e_addr = (k < 8) ? base + 16'(2 * k) : base;
            if (nresp < 8 && k == resp_cyc[nresp]) begin
                v.dv     = 1'b1;
                v.mdata  = wdata(base, nresp);
                v.e_wr   = 1'b1;
                v.e_data = v.mdata;
                v.e_off  = 3'(nresp);
                v.e_tag  = (nresp == 7);
                v.e_done = (nresp == 7);
                nresp++;
            end
            vq.push_back(v);
        end
        if (stop_at < 8) begin
            v = idle_vec(); v.rst = 1'b1; v.full_chk = 1'b1;
            vq.push_back(v);
        end
        if (idle_after) vq.push_back(idle_vec());
    endtask

    initial begin
        vec_t v;
        n_vec = 0; n_err = 0;
        rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0;
        memory_data_valid = 1'b0; memory_data = 16'h0;

        // Reset then idle: everything zero, no requests.
        v = idle_vec(); v.rst = 1'b1; v.full_chk = 1'b1;
        vq.push_back(v); vq.push_back(v);
        for (int i = 0; i < 10; i++) begin
            v = idle_vec(); v.full_chk = 1'b1;
            vq.push_back(v);
        end
        run_section();
        chk("idle_busy_cycles", busy_cnt, 0);
        chk("idle_req_count", rd_cnt, 0);

        // Basic fill at 0x1236.
        build_fill(16'h1236, 8, 0, 8, 1'b0, 1'b1);
        run_section();
        chk("basic_busy_cycles", busy_cnt, 13);
        chk("basic_req_count", rd_cnt, 8);
        chk("basic_done_index", done_idx, 12);
        chk("basic_tag_count", tag_cnt, 1);

        // Gapped responses: two idle cycles between word 3 and word 4.
        build_fill(16'h2468, 4, 2, 8, 1'b0, 1'b1);
        run_section();
        chk("gap_done_index", done_idx, 14);
        chk("gap_write_count", wr_cnt, 8);

        // Block at top of address space, followed back-to-back by a new miss.
        build_fill(16'hFFFA, 8, 0, 8, 1'b0, 1'b0);
        build_fill(16'h0A10, 8, 0, 8, 1'b0, 1'b1);
        run_section();
        chk("wrap_zero_req", zero_req, 0);
        chk("wrap_req_count", rd_cnt, 16);
        chk("wrap_tag_count", tag_cnt, 2);

        // Reset after five data writes: no tag write.
        build_fill(16'h2000, 8, 0, 5, 1'b0, 1'b1);
        run_section();
        chk("midrst_tag_count", tag_cnt, 0);
        chk("midrst_write_count", wr_cnt, 5);

        // Clean fill after the aborted one.
        build_fill(16'h0040, 8, 0, 8, 1'b0, 1'b1);
        run_section();
        chk("post_rst_write_count", wr_cnt, 8);
        chk("post_rst_tag_count", tag_cnt, 1);

        // Spurious inputs: data valid in IDLE, other-address misses during FILL.
        v = idle_vec(); v.dv = 1'b1; v.mdata = 16'hDEAD;
        vq.push_back(v); vq.push_back(v);
        vq.push_back(idle_vec());
        build_fill(16'h3334, 8, 0, 8, 1'b1, 1'b1);
        v = idle_vec(); v.dv = 1'b1; v.mdata = 16'hBEEF;
        vq.push_back(v);
        run_section();
        chk("spurious_write_count", wr_cnt, 8);
        chk("spurious_busy_cycles", busy_cnt, 13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
